// File: rtl/reset_sequencer.sv
// Staged reset release for core, peripheral and host domains.
// Reset causes: power-on (reset_n), debounced front-panel button, software request.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// HOLD       | all stage resets asserted, hold timer running
// REL_CORE   | core released, stage timer running
// REL_PERIPH | core and peripherals released, stage timer running
// REL_HOST   | host released this cycle, busy drops with it
// RUN        | everything released, waiting for the next reset cause
module reset_sequencer #(
   parameter int DEB_W     = 16,
   parameter int STAGE_CYC = 32,
   parameter int HOLD_CYC  = 64
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       pb_n,
   input  logic       sw_rst_req,
   output logic       rst_core_n,
   output logic       rst_periph_n,
   output logic       rst_host_n,
   output logic       busy,
   output logic [1:0] last_cause
);

   typedef enum logic [2:0] {
      HOLD       = 3'd0,
      REL_CORE   = 3'd1,
      REL_PERIPH = 3'd2,
      REL_HOST   = 3'd3,
      RUN        = 3'd4
   } state_t;

   localparam logic [7:0]       HOLD_TC  = 8'(HOLD_CYC - 1);
   localparam logic [7:0]       STAGE_TC = 8'(STAGE_CYC - 1);
   localparam logic [DEB_W-1:0] DEB_MAX  = '1;
   localparam logic [DEB_W-1:0] DEB_PRE  = {{(DEB_W-1){1'b1}}, 1'b0};
   localparam logic [DEB_W-1:0] DEB_ONE  = {{(DEB_W-1){1'b0}}, 1'b1};

   state_t           state, state_nxt;
   logic [7:0]       cnt, cnt_nxt;
   logic             pb_meta, pb_sync;
   logic [DEB_W-1:0] deb_cnt;
   logic             pb_evt;
   logic             cause_acc;
   logic             core_nxt, periph_nxt, host_nxt, busy_nxt;

   // two-flop synchroniser for the raw button, idle level is released (1)
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pb_meta <= 1'b1;
         pb_sync <= 1'b1;
      end else begin
         pb_meta <= pb_n;
         pb_sync <= pb_meta;
      end
   end

   // debounce counter: counts while pressed, clears on release, saturates
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         deb_cnt <= '0;
      end else if (pb_sync) begin
         deb_cnt <= '0;
      end else if (deb_cnt != DEB_MAX) begin
         deb_cnt <= deb_cnt + DEB_ONE;
      end
   end

   // the press registers on the step into saturation, so a held button fires once
   assign pb_evt    = !pb_sync && (deb_cnt == DEB_PRE);
   assign cause_acc = (pb_evt || sw_rst_req) && (state != HOLD);

   // state and stage timer register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= HOLD;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // next state, timer and output levels; a reset cause overrides everything
   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      core_nxt   = 1'b0;
      periph_nxt = 1'b0;
      host_nxt   = 1'b0;
      busy_nxt   = 1'b1;
      case (state)
         HOLD: begin
            if (cnt == HOLD_TC) begin
               state_nxt = REL_CORE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + 8'd1;
            end
         end
         REL_CORE: begin
            core_nxt = 1'b1;
            if (cnt == STAGE_TC) begin
               state_nxt = REL_PERIPH;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + 8'd1;
            end
         end
         REL_PERIPH: begin
            core_nxt   = 1'b1;
            periph_nxt = 1'b1;
            if (cnt == STAGE_TC) begin
               state_nxt = REL_HOST;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + 8'd1;
            end
         end
         REL_HOST: begin
            core_nxt   = 1'b1;
            periph_nxt = 1'b1;
            host_nxt   = 1'b1;
            busy_nxt   = 1'b0;
            state_nxt  = RUN;
            cnt_nxt    = '0;
         end
         RUN: begin
            core_nxt   = 1'b1;
            periph_nxt = 1'b1;
            host_nxt   = 1'b1;
            busy_nxt   = 1'b0;
         end
         default: begin
            state_nxt = HOLD;
            cnt_nxt   = '0;
         end
      endcase
      if (cause_acc) begin
         state_nxt  = HOLD;
         cnt_nxt    = '0;
         core_nxt   = 1'b0;
         periph_nxt = 1'b0;
         host_nxt   = 1'b0;
         busy_nxt   = 1'b1;
      end
   end

   // registered outputs, one cycle behind the state so releases are glitch-free
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rst_core_n   <= 1'b0;
         rst_periph_n <= 1'b0;
         rst_host_n   <= 1'b0;
         busy         <= 1'b1;
      end else begin
         rst_core_n   <= core_nxt;
         rst_periph_n <= periph_nxt;
         rst_host_n   <= host_nxt;
         busy         <= busy_nxt;
      end
   end

   // cause capture; the button wins when both arrive together
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         last_cause <= 2'b00;
      end else if (cause_acc) begin
         last_cause <= pb_evt ? 2'b01 : 2'b10;
      end
   end

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: stimulus pushes expected output changes (cycle, value)
// into a queue; a monitor pops one entry for every observed output change.
module tb_reset_sequencer;

   localparam int HOLD  = 64;
   localparam int STAGE = 32;

   logic       clk = 1'b0;
   logic       reset_n = 1'b1;
   logic       pb_n = 1'b1;
   logic       sw_rst_req = 1'b0;
   logic       rst_core_n, rst_periph_n, rst_host_n, busy;
   logic [1:0] last_cause;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   typedef struct {
      int         cyc;
      logic [5:0] v;
   } exp_t;

   exp_t exp_q[$];

   reset_sequencer #(
      .DEB_W(4),
      .STAGE_CYC(STAGE),
      .HOLD_CYC(HOLD)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .pb_n(pb_n),
      .sw_rst_req(sw_rst_req),
      .rst_core_n(rst_core_n),
      .rst_periph_n(rst_periph_n),
      .rst_host_n(rst_host_n),
      .busy(busy),
      .last_cause(last_cause)
   );

   // 10 ns clock
   always #5 clk = ~clk;

   // edge counter shared by stimulus and monitor
   always @(posedge clk) cyc <= cyc + 1;

   wire [5:0] obs = {rst_core_n, rst_periph_n, rst_host_n, busy, last_cause};

   // monitor: every change of the output vector must match the queue head
   logic [5:0] prev = 6'b000100;
   always @(negedge clk) begin
      if (obs !== prev) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_change cyc=%0d got=%b (no change expected)", cyc, obs);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (e.cyc != cyc || e.v !== obs) begin
               errors++;
               $display("FAIL out_change got cyc=%0d val=%b expected cyc=%0d val=%b",
                        cyc, obs, e.cyc, e.v);
            end
         end
      end
      prev = obs;
   end

   // expected changes of one sequence starting with the FSM entering HOLD at edge base
   task automatic push_seq(input int base, input logic [1:0] cause,
                           input bit with_base, input int upto);
      exp_t e;
      if (with_base) begin
         e.cyc = base;             e.v = {4'b0001, cause}; exp_q.push_back(e);
      end
      if (base + HOLD + 1 <= upto) begin
         e.cyc = base + HOLD + 1;  e.v = {4'b1001, cause}; exp_q.push_back(e);
      end
      if (base + HOLD + STAGE + 1 <= upto) begin
         e.cyc = base + HOLD + STAGE + 1; e.v = {4'b1101, cause}; exp_q.push_back(e);
      end
      if (base + HOLD + 2*STAGE + 1 <= upto) begin
         e.cyc = base + HOLD + 2*STAGE + 1; e.v = {4'b1110, cause}; exp_q.push_back(e);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic settle_until(input int target);
      while (cyc < target) tick(1);
   endtask

   localparam int BIG = 1 << 30;

   initial begin
      int c, r, e1, e2;

      // power-on reset and reset-state check
      #1 reset_n = 1'b0;
      #1;
      checks++;
      if (obs !== 6'b000100) begin
         errors++;
         $display("FAIL reset_state got=%b expected=%b", obs, 6'b000100);
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      r = cyc;
      push_seq(r, 2'b00, 1'b0, BIG);
      reset_n = 1'b1;
      settle_until(r + 135);

      // bounce shorter than the debounce window, then a stable press
      pb_n = 1'b0;
      tick(10);
      pb_n = 1'b1;
      tick(5);
      c = cyc;
      push_seq(c + 17, 2'b01, 1'b1, BIG);
      pb_n = 1'b0;
      tick(20);
      pb_n = 1'b1;
      settle_until(c + 17 + 135);

      // software reset from RUN
      c = cyc;
      push_seq(c + 1, 2'b10, 1'b1, BIG);
      sw_rst_req = 1'b1;
      tick(1);
      sw_rst_req = 1'b0;
      settle_until(c + 1 + 135);

      // button event and software request on the same edge
      c = cyc;
      push_seq(c + 17, 2'b01, 1'b1, BIG);
      pb_n = 1'b0;
      tick(16);
      sw_rst_req = 1'b1;
      tick(1);
      sw_rst_req = 1'b0;
      settle_until(c + 17 + 135);
      pb_n = 1'b1;
      tick(5);

      // abort in REL_PERIPH, then causes during HOLD are ignored
      c = cyc;
      e1 = c + 1;
      e2 = e1 + 110;
      push_seq(e1, 2'b10, 1'b1, e2 - 1);
      sw_rst_req = 1'b1;
      tick(1);
      sw_rst_req = 1'b0;
      settle_until(e2 - 1);
      push_seq(e2, 2'b10, 1'b1, BIG);
      sw_rst_req = 1'b1;
      tick(1);
      sw_rst_req = 1'b0;
      tick(4);
      pb_n = 1'b0;
      tick(30);
      sw_rst_req = 1'b1;
      tick(1);
      sw_rst_req = 1'b0;
      settle_until(e2 + 135);
      pb_n = 1'b1;
      tick(5);

      // short asynchronous reset pulse while in RUN
      c = cyc;
      #1;
      push_seq(c, 2'b00, 1'b1, BIG);
      reset_n = 1'b0;
      #1;
      checks++;
      if (obs !== 6'b000100) begin
         errors++;
         $display("FAIL async_reset got=%b expected=%b", obs, 6'b000100);
      end
      #1 reset_n = 1'b1;
      settle_until(c + 135);

      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL missing_changes got=%0d pending expected=0", exp_q.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Consumes the board-level power-on reset and produces staged, glitch-free reset releases for the core logic, peripheral controllers and host interface.
- Also handles a debounced front-panel pushbutton and a single-cycle software reset request from the host command decoder.
- Sits directly downstream of the power-on reset generator; its outputs feed every other block in the design.

Parameters:
- DEB_W, 16, width of the pushbutton debounce counter; the press must be stable for 2^DEB_W - 1 cycles.
- STAGE_CYC, 32, cycles between consecutive stage releases; legal range 2..255.
- HOLD_CYC, 64, minimum cycles all resets are held asserted after a reset cause; legal range 2..255.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  global reset, asynchronous assert, active-low (power-on reset, inverted at top level).
- pb_n  input  1  raw front-panel pushbutton, active-low, asynchronous and bouncy.
- sw_rst_req  input  1  single-cycle software reset request, synchronous to clk.
- rst_core_n  output  1  core reset, active-low, registered.
- rst_periph_n  output  1  peripheral reset, active-low, registered.
- rst_host_n  output  1  host-interface reset, active-low, registered.
- busy  output  1  high while any stage reset is asserted.
- last_cause  output  2  cause of the most recent reset: 00 power-on, 01 pushbutton, 10 software.

Behaviour:
- Asynchronous reset (reset_n low):
  - All rst_*_n = 0, busy = 1, last_cause = 00.
  - FSM goes to HOLD; hold counter = 0; debounce counter = 0; pushbutton synchroniser = released.
- Pushbutton input path:
  - pb_n passes through a 2-flop synchroniser (flops reset to 1).
  - The debounce counter increments while the synchronised pb_n is 0 and clears to 0 whenever it is 1.
  - It saturates at all-ones. pb_evt is a one-cycle pulse on the transition into all-ones.
  - A button held down produces one pb_evt only; the button must be released (counter clears) before another press can register.
- FSM states: HOLD, REL_CORE, REL_PERIPH, REL_HOST, RUN.
  - HOLD: all outputs 0. Counter runs 0..HOLD_CYC-1. At HOLD_CYC-1, move to REL_CORE and clear the counter.
  - REL_CORE: rst_core_n = 1 on entry (registered, so visible the cycle after the HOLD exit). Count to STAGE_CYC-1, then move to REL_PERIPH.
  - REL_PERIPH: rst_periph_n = 1. Count to STAGE_CYC-1, then move to REL_HOST.
  - REL_HOST: rst_host_n = 1. Move to RUN the next cycle.
  - RUN: all outputs 1, busy = 0. Remain until a reset cause arrives.
- Timing from reset_n deassertion (counter starts on the first clk edge after deassertion):
  - rst_core_n rises after HOLD_CYC+1 cycles.
  - rst_periph_n rises STAGE_CYC cycles after that.
  - rst_host_n rises STAGE_CYC cycles after rst_periph_n.
  - busy falls in the same cycle rst_host_n rises.
- Reset causes (sw_rst_req, pb_evt):
  - Accepted in any state other than HOLD.
  - On acceptance, the FSM goes to HOLD on the next edge, all outputs drop to 0 on that same edge, and the counter clears.
  - last_cause updates on the acceptance edge.
- Boundary conditions:
  - sw_rst_req and pb_evt in the same cycle: last_cause = 01 (pushbutton wins).
  - A cause arriving during HOLD is ignored and the counter is not restarted. A held button cannot re-trigger because its pb_evt has already fired.
  - A cause arriving mid-sequence (REL_*) aborts the sequence: all stages are re-asserted immediately and the sequence restarts from HOLD.
  - reset_n asserting at any time overrides everything asynchronously.
- Output and counter rules:
  - Outputs come directly from flops, with no combinational path from inputs to outputs.
  - Outputs are monotonic during a sequence: once released, a stage reset stays released until the next reset cause.
  - The stage counter is 8 bits wide and never wraps in legal configurations.

Test Plan:
- Power-on: deassert reset_n with HOLD_CYC = 64 and STAGE_CYC = 32 -> rst_core_n rises at cycle 65, rst_periph_n at 97, rst_host_n at 129. busy falls at 129. last_cause = 00.
- Software reset: in RUN, pulse sw_rst_req for one cycle -> all outputs 0 on the next edge and last_cause = 10. The full sequence replays: core released 65 cycles later, host 129 cycles later.
- Pushbutton debounce: with DEB_W = 4, bounce pb_n low for 10 cycles then high, then hold it low for 20 cycles -> no reset during the bounce. The reset occurs on cycle 17 of the stable low (2 synchroniser cycles + 15 count cycles), exactly once, and last_cause = 01.
- Simultaneous causes: pb_evt and sw_rst_req in the same cycle -> one restart, last_cause = 01.
- Abort mid-sequence: pulse sw_rst_req while in REL_PERIPH (core released, periph released) -> both drop to 0 on the next edge and the HOLD count restarts from 0.
- Async reset mid-operation: pull reset_n low for a partial cycle in RUN -> outputs go to 0 immediately, without waiting for a clk edge. last_cause = 00 and busy = 1.
